// File: rtl/topk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// topk_pkg : default sizes, FSM state type and slot type for the top-K selector
// Rev 1.0
// ---------------------------------------------------------------------------
package topk_pkg;

    localparam int TOPK_DATA_W = 13;
    localparam int TOPK_K      = 6;
    localparam int TOPK_N      = 32;
    localparam int TOPK_IDX_W  = $clog2(TOPK_N);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    // Slot layout at the default sizes; the top keeps the fields in separate
    // arrays so DATA_W/N overrides and the index-less build stay consistent.
    typedef struct packed {
        logic                   occupied;
        logic [TOPK_DATA_W-1:0] value;
        logic [TOPK_IDX_W-1:0]  idx;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/topk_cmp_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// topk_cmp_cell : combinational "sample beats slot" comparator, one per slot
// Rev 1.0
// ---------------------------------------------------------------------------
module topk_cmp_cell
    import topk_pkg::*;
#(
    parameter int DATA_W = TOPK_DATA_W
)(
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W:0]   i_slot,
    input  logic              i_mode,
    output logic              o_beats
);

    logic              w_occ;
    logic [DATA_W-1:0] w_val;

    assign w_occ = i_slot[DATA_W];
    assign w_val = i_slot[DATA_W-1:0];

    // Strict compare: an equal later sample never displaces an earlier one.
    assign o_beats = !w_occ || (i_mode ? (i_sample < w_val) : (i_sample > w_val));

endmodule
`default_nettype wire

// File: rtl/topk_stream_selector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// topk_stream_selector : streaming sorted top-K selector over N-sample frames
// Option macro TOPK_INDEX_EN adds per-slot in-frame index storage.  Rev 1.0
// ---------------------------------------------------------------------------
module topk_stream_selector
    import topk_pkg::*;
#(
    parameter int DATA_W = TOPK_DATA_W,
    parameter int K      = TOPK_K,
    parameter int N      = TOPK_N,
    parameter int IDX_W  = $clog2(N)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [DATA_W-1:0]           i_in_data,
    input  logic                        i_mode_min,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [0:K-1][DATA_W-1:0]    o_out_data,
    output logic [0:K-1][IDX_W-1:0]     o_out_idx,
    output logic                        o_out_mode
);

    localparam int POS_W = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic [K-1:0]      r_occ;
    logic [DATA_W-1:0] r_val [K];

    logic              w_accept;
    logic              w_mode;
    logic [K-1:0]      w_beats;
    logic              w_hit;
    logic [POS_W-1:0]  w_pos;
    logic [K-1:0]      w_occ_nxt;
    logic [DATA_W-1:0] w_val_nxt [K];

    assign w_accept = i_in_valid && r_in_ready;
    assign w_mode   = (r_cnt == '0) ? i_mode_min : r_mode;

    generate
        for (genvar j = 0; j < K; j++) begin : g_cell
            topk_cmp_cell #(.DATA_W(DATA_W)) u_cell (
                .i_sample (i_in_data),
                .i_slot   ({r_occ[j], r_val[j]}),
                .i_mode   (w_mode),
                .o_beats  (w_beats[j])
            );
        end
    endgenerate

    // Lowest beaten slot wins; scanning downward lets the last hit stand.
    always_comb begin
        w_hit = 1'b0;
        w_pos = '0;
        for (int j = K - 1; j >= 0; j--) begin
            if (w_beats[j]) begin
                w_hit = 1'b1;
                w_pos = POS_W'(j);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_occ_nxt[j] = r_occ[j];
            w_val_nxt[j] = r_val[j];
            if (w_hit) begin
                if (j == int'(w_pos)) begin
                    w_occ_nxt[j] = 1'b1;
                    w_val_nxt[j] = i_in_data;
                end else if (j > int'(w_pos) && j > 0) begin
                    w_occ_nxt[j] = r_occ[j-1];
                    w_val_nxt[j] = r_val[j-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_occ       <= '0;
            for (int j = 0; j < K; j++) r_val[j] <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == '0) r_mode <= i_mode_min;
                        r_occ <= w_occ_nxt;
                        for (int j = 0; j < K; j++) r_val[j] <= w_val_nxt[j];
                        if (r_cnt == c_LAST) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state     <= COLLECT;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_occ       <= '0;
                        for (int j = 0; j < K; j++) r_val[j] <= '0;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

`ifdef TOPK_INDEX_EN
    logic [IDX_W-1:0] r_idx     [K];
    logic [IDX_W-1:0] w_idx_nxt [K];

    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_idx_nxt[j] = r_idx[j];
            if (w_hit) begin
                if (j == int'(w_pos)) begin
                    w_idx_nxt[j] = r_cnt[IDX_W-1:0];
                end else if (j > int'(w_pos) && j > 0) begin
                    w_idx_nxt[j] = r_idx[j-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < K; j++) r_idx[j] <= '0;
        end else if (r_state == COLLECT && w_accept) begin
            for (int j = 0; j < K; j++) r_idx[j] <= w_idx_nxt[j];
        end else if (r_state == DONE && i_out_ready) begin
            for (int j = 0; j < K; j++) r_idx[j] <= '0;
        end
    end

    generate
        for (genvar j = 0; j < K; j++) begin : g_idx_out
            assign o_out_idx[j] = r_idx[j];
        end
    endgenerate
`else
    assign o_out_idx = '0;
`endif

    generate
        for (genvar j = 0; j < K; j++) begin : g_data_out
            assign o_out_data[j] = r_val[j];
        end
    endgenerate

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_topk_stream_selector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_topk_stream_selector : directed bench for topk_stream_selector (K=6,N=32)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_topk_stream_selector;

    logic               clk;
    logic               rst_n;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [12:0]        i_in_data;
    logic               i_mode_min;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [0:5][12:0]   o_out_data;
    logic [0:5][4:0]    o_out_idx;
    logic               o_out_mode;

    int                 total;
    int                 bad;
    logic [12:0]        fd [32];
    logic [12:0]        ev [6];
    int                 ei [6];

    topk_stream_selector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_mode_min  (i_mode_min),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_idx   (o_out_idx),
        .o_out_mode  (o_out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] exp_idx(input int v);
`ifdef TOPK_INDEX_EN
        return 5'(v);
`else
        return 5'd0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the last accept.
    task automatic send_range(input int first, input int last, input logic mode);
        for (int i = first; i <= last; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = fd[i];
            i_mode_min = (i == 0) ? mode : ~mode;
            @(posedge clk);
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        i_mode_min = 1'b0;
    endtask

    task automatic handshake();
        i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_out_ready = 1'b0;
    endtask

    // Repeated selection of the best unused sample; first index wins ties.
    task automatic model_topk(input logic mode);
        logic used [32];
        int   b;
        for (int i = 0; i < 32; i++) used[i] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            b = -1;
            for (int i = 0; i < 32; i++) begin
                if (!used[i]) begin
                    if (b < 0) b = i;
                    else if (mode ? (fd[i] < fd[b]) : (fd[i] > fd[b])) b = i;
                end
            end
            used[b] = 1'b1;
            ev[s]   = fd[b];
            ei[s]   = b;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); end
        total++; if (o_out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", o_out_data); end
        total++; if (o_out_idx !== '0) begin bad++; $display("FAIL reset_out_idx got=%h exp=0", o_out_idx); end
        total++; if (o_out_mode !== 1'b0) begin bad++; $display("FAIL reset_out_mode got=%b exp=0", o_out_mode); end
    endtask

    task automatic test_max_ascending();
        for (int i = 0; i < 32; i++) fd[i] = 13'(i);
        send_range(0, 30, 1'b0);
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL max_early_valid got=%b exp=0", o_out_valid); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL max_early_ready got=%b exp=1", o_in_ready); end
        send_range(31, 31, 1'b0);
        total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL max_valid got=%b exp=1", o_out_valid); end
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL max_in_ready got=%b exp=0", o_in_ready); end
        for (int j = 0; j < 6; j++) begin
            total++; if (o_out_data[j] !== 13'(31 - j)) begin bad++; $display("FAIL max_data slot%0d got=%0d exp=%0d", j, o_out_data[j], 31 - j); end
            total++; if (o_out_idx[j] !== exp_idx(31 - j)) begin bad++; $display("FAIL max_idx slot%0d got=%0d exp=%0d", j, o_out_idx[j], exp_idx(31 - j)); end
        end
        total++; if (o_out_mode !== 1'b0) begin bad++; $display("FAIL max_mode got=%b exp=0", o_out_mode); end
        handshake();
    endtask

    task automatic test_min_descending();
        for (int i = 0; i < 32; i++) fd[i] = 13'(31 - i);
        send_range(0, 31, 1'b1);
        total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL min_valid got=%b exp=1", o_out_valid); end
        for (int j = 0; j < 6; j++) begin
            total++; if (o_out_data[j] !== 13'(j)) begin bad++; $display("FAIL min_data slot%0d got=%0d exp=%0d", j, o_out_data[j], j); end
            total++; if (o_out_idx[j] !== exp_idx(31 - j)) begin bad++; $display("FAIL min_idx slot%0d got=%0d exp=%0d", j, o_out_idx[j], exp_idx(31 - j)); end
        end
        total++; if (o_out_mode !== 1'b1) begin bad++; $display("FAIL min_mode got=%b exp=1", o_out_mode); end
        handshake();
    endtask

    task automatic test_ties();
        for (int i = 0; i < 32; i++) fd[i] = 13'h1FFF;
        send_range(0, 31, 1'b0);
        for (int j = 0; j < 6; j++) begin
            total++; if (o_out_data[j] !== 13'd8191) begin bad++; $display("FAIL tie_data slot%0d got=%0d exp=8191", j, o_out_data[j]); end
            total++; if (o_out_idx[j] !== exp_idx(j)) begin bad++; $display("FAIL tie_idx slot%0d got=%0d exp=%0d", j, o_out_idx[j], exp_idx(j)); end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int bp_v [6];
        int bp_i [6];
        bp_v = '{31, 30, 29, 28, 27, 26};
        bp_i = '{9, 18, 27, 4, 13, 22};
        for (int i = 0; i < 32; i++) fd[i] = 13'((i * 7) % 32);
        send_range(0, 31, 1'b0);
        for (int c = 0; c < 10; c++) begin
            i_in_valid = 1'b1;
            i_in_data  = 13'h1FFF;
            @(negedge clk);
            total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc%0d got=%b exp=1", c, o_out_valid); end
            total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", c, o_in_ready); end
            for (int j = 0; j < 6; j++) begin
                total++; if (o_out_data[j] !== 13'(bp_v[j])) begin bad++; $display("FAIL bp_data cyc%0d slot%0d got=%0d exp=%0d", c, j, o_out_data[j], bp_v[j]); end
                total++; if (o_out_idx[j] !== exp_idx(bp_i[j])) begin bad++; $display("FAIL bp_idx cyc%0d slot%0d got=%0d exp=%0d", c, j, o_out_idx[j], exp_idx(bp_i[j])); end
            end
        end
        i_in_valid = 1'b0;
        handshake();
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", o_in_ready); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", o_out_valid); end
        total++; if (o_out_data !== '0) begin bad++; $display("FAIL bp_cleared_data got=%h exp=0", o_out_data); end
        total++; if (o_out_idx !== '0) begin bad++; $display("FAIL bp_cleared_idx got=%h exp=0", o_out_idx); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) fd[i] = 13'(100 + i);
        send_range(0, 31, 1'b0);
        handshake();
        for (int i = 0; i < 32; i++) fd[i] = 13'(31 - i);
        send_range(0, 31, 1'b0);
        total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", o_out_valid); end
        for (int j = 0; j < 6; j++) begin
            total++; if (o_out_data[j] !== 13'(31 - j)) begin bad++; $display("FAIL b2b_data slot%0d got=%0d exp=%0d", j, o_out_data[j], 31 - j); end
            total++; if (o_out_idx[j] !== exp_idx(j)) begin bad++; $display("FAIL b2b_idx slot%0d got=%0d exp=%0d", j, o_out_idx[j], exp_idx(j)); end
        end
        handshake();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 32; i++) fd[i] = 13'(500 + i);
        send_range(0, 16, 1'b1);
        rst_n = 1'b0;
        #1;
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", o_in_ready); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", o_out_valid); end
        total++; if (o_out_data !== '0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", o_out_data); end
        total++; if (o_out_idx !== '0) begin bad++; $display("FAIL mid_rst_idx got=%h exp=0", o_out_idx); end
        total++; if (o_out_mode !== 1'b0) begin bad++; $display("FAIL mid_rst_mode got=%b exp=0", o_out_mode); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) fd[i] = 13'($urandom_range(0, 8191));
        model_topk(1'b0);
        send_range(0, 31, 1'b0);
        total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL mid_frame_valid got=%b exp=1", o_out_valid); end
        for (int j = 0; j < 6; j++) begin
            total++; if (o_out_data[j] !== ev[j]) begin bad++; $display("FAIL mid_frame_data slot%0d got=%0d exp=%0d", j, o_out_data[j], ev[j]); end
            total++; if (o_out_idx[j] !== exp_idx(ei[j])) begin bad++; $display("FAIL mid_frame_idx slot%0d got=%0d exp=%0d", j, o_out_idx[j], exp_idx(ei[j])); end
        end
        handshake();
    endtask

    task automatic test_random();
        logic m;
        for (int f = 0; f < 4; f++) begin
            m = f[0];
            for (int i = 0; i < 32; i++)
                fd[i] = (f < 2) ? 13'($urandom_range(0, 15)) : 13'($urandom_range(0, 8191));
            model_topk(m);
            send_range(0, 31, m);
            total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid frame%0d got=%b exp=1", f, o_out_valid); end
            total++; if (o_out_mode !== m) begin bad++; $display("FAIL rnd_mode frame%0d got=%b exp=%b", f, o_out_mode, m); end
            for (int j = 0; j < 6; j++) begin
                total++; if (o_out_data[j] !== ev[j]) begin bad++; $display("FAIL rnd_data frame%0d slot%0d got=%0d exp=%0d", f, j, o_out_data[j], ev[j]); end
                total++; if (o_out_idx[j] !== exp_idx(ei[j])) begin bad++; $display("FAIL rnd_idx frame%0d slot%0d got=%0d exp=%0d", f, j, o_out_idx[j], exp_idx(ei[j])); end
            end
            handshake();
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_mode_min  = 1'b0;
        i_out_ready = 1'b0;
        test_reset();
        test_max_ascending();
        test_min_descending();
        test_ties();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
